// File: rtl/spi_master_tx.sv
`default_nettype none
// ============================================================================
//  Module   : spi_master_tx
//  Purpose  : SPI mode-0 master transmitter, MSB first. Bytes arrive on a
//             valid/ready stream through a one-entry hold register. The
//             byte_last_in flag closes a chip-select frame. Consecutive
//             non-last bytes stream with no sclk gap.
//  Options  : SPI_MISO_EN adds a MISO receive shifter that samples on sclk
//             rise and presents rx_data_out/rx_valid_out with byte_done_out.
//  Revision : 1.0 - initial release
// ============================================================================
module spi_master_tx #(
    parameter int CLK_DIV = 2,
    parameter int CS_IDLE = 4
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       byte_valid_in,
    output logic       byte_ready_out,
    input  logic [7:0] byte_data_in,
    input  logic       byte_last_in,
    output logic       byte_done_out,
    output logic       busy_out,
    output logic       spi_sclk_out,
    output logic       spi_mosi_out,
    output logic       spi_cs_n_out
`ifdef SPI_MISO_EN
    ,
    input  logic       spi_miso_in,
    output logic [7:0] rx_data_out,
    output logic       rx_valid_out
`endif
);

    localparam int HW = $clog2(CLK_DIV + 1);
    localparam int GW = $clog2(CS_IDLE + 1);
    localparam logic [HW-1:0] HALF_MAX = HW'(CLK_DIV - 1);
    localparam logic [HW-1:0] HALF_ONE = HW'(1);
    localparam logic [GW-1:0] GAP_MAX  = GW'(CS_IDLE - 1);
    localparam logic [GW-1:0] GAP_ONE  = GW'(1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SHIFT = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        GAP   = 3'd4
    } state_t;

    state_t        state, state_nxt;
    logic [HW-1:0] half_cnt, half_nxt;
    logic [2:0]    bit_cnt, bit_nxt;
    logic [GW-1:0] gap_cnt, gap_nxt;
    logic [7:0]    shifter, shift_nxt;
    logic          cur_last, last_nxt;
    logic          hold_valid, hold_valid_nxt;
    logic [7:0]    hold_data, hold_data_nxt;
    logic          hold_last, hold_last_nxt;
    logic          sclk, sclk_nxt;
    logic          mosi, mosi_nxt;
    logic          cs_n, cs_n_nxt;
    logic          done, done_nxt;
    logic          load;
    logic          rise;
    logic          accept;

    assign accept         = byte_valid_in && !hold_valid;
    assign byte_ready_out = !hold_valid;
    assign busy_out       = (state != IDLE);
    assign byte_done_out  = done;
    assign spi_sclk_out   = sclk;
    assign spi_mosi_out   = mosi;
    assign spi_cs_n_out   = cs_n;

    // State and datapath registers; reset drops the frame immediately.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state      <= IDLE;
            half_cnt   <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            shifter    <= '0;
            cur_last   <= 1'b0;
            hold_valid <= 1'b0;
            hold_data  <= '0;
            hold_last  <= 1'b0;
            sclk       <= 1'b0;
            mosi       <= 1'b0;
            cs_n       <= 1'b1;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            half_cnt   <= half_nxt;
            bit_cnt    <= bit_nxt;
            gap_cnt    <= gap_nxt;
            shifter    <= shift_nxt;
            cur_last   <= last_nxt;
            hold_valid <= hold_valid_nxt;
            hold_data  <= hold_data_nxt;
            hold_last  <= hold_last_nxt;
            sclk       <= sclk_nxt;
            mosi       <= mosi_nxt;
            cs_n       <= cs_n_nxt;
            done       <= done_nxt;
        end
    end

    // Next-state, sclk phase timing, shifter and hold-register handoff.
    always_comb begin
        state_nxt = state;
        half_nxt  = half_cnt;
        bit_nxt   = bit_cnt;
        gap_nxt   = gap_cnt;
        shift_nxt = shifter;
        last_nxt  = cur_last;
        sclk_nxt  = sclk;
        mosi_nxt  = mosi;
        cs_n_nxt  = cs_n;
        done_nxt  = 1'b0;
        load      = 1'b0;
        rise      = 1'b0;

        case (state)
            IDLE: load = hold_valid;
            SHIFT: begin
                if (half_cnt == HALF_MAX) begin
                    half_nxt = '0;
                    if (!sclk) begin
                        sclk_nxt = 1'b1;
                        rise     = 1'b1;
                    end else begin
                        sclk_nxt = 1'b0;
                        bit_nxt  = bit_cnt + 3'd1;
                        if (bit_cnt != 3'd7) begin
                            shift_nxt = {shifter[6:0], 1'b0};
                            mosi_nxt  = shifter[6];
                        end else begin
                            // Byte complete: close frame, chain next byte, or stall.
                            done_nxt = 1'b1;
                            if (cur_last) begin
                                state_nxt = HOLD;
                            end else if (hold_valid) begin
                                load = 1'b1;
                            end else begin
                                state_nxt = WAIT;
                            end
                        end
                    end
                end else begin
                    half_nxt = half_cnt + HALF_ONE;
                end
            end
            WAIT: load = hold_valid;
            HOLD: begin
                if (half_cnt == HALF_MAX) begin
                    half_nxt  = '0;
                    cs_n_nxt  = 1'b1;
                    gap_nxt   = '0;
                    state_nxt = GAP;
                end else begin
                    half_nxt = half_cnt + HALF_ONE;
                end
            end
            GAP: begin
                // A byte already held starts right as the gap expires.
                if (gap_cnt == GAP_MAX) begin
                    if (hold_valid) begin
                        load = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    gap_nxt = gap_cnt + GAP_ONE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (load) begin
            state_nxt = SHIFT;
            shift_nxt = hold_data;
            last_nxt  = hold_last;
            mosi_nxt  = hold_data[7];
            cs_n_nxt  = 1'b0;
            sclk_nxt  = 1'b0;
            half_nxt  = '0;
            bit_nxt   = '0;
        end

        hold_valid_nxt = (hold_valid && !load) || accept;
        hold_data_nxt  = accept ? byte_data_in : hold_data;
        hold_last_nxt  = accept ? byte_last_in : hold_last;
    end

`ifdef SPI_MISO_EN
    logic [7:0] rx_shift;
    logic [7:0] rx_data;
    logic       rx_valid;

    assign rx_data_out  = rx_data;
    assign rx_valid_out = rx_valid;

    // MISO capture on sclk rise; word published alongside byte_done.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rx_shift <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            rx_valid <= done_nxt;
            if (rise) begin
                rx_shift <= {rx_shift[6:0], spi_miso_in};
            end
            if (done_nxt) begin
                rx_data <= rx_shift;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_master_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_master_tx
//  Purpose  : Self-checking bench for spi_master_tx. A monitor rebuilds each
//             byte from mosi at sclk rises and compares it with the byte
//             queued at handshake; frame, gap and phase timing are measured.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spi_master_tx;

    localparam int CLK_DIV = 2;
    localparam int CS_IDLE = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       byte_valid = 1'b0;
    logic       byte_ready;
    logic [7:0] byte_data = 8'h00;
    logic       byte_last = 1'b0;
    logic       byte_done;
    logic       busy;
    logic       sclk;
    logic       mosi;
    logic       cs_n;
`ifdef SPI_MISO_EN
    logic [7:0] rx_data;
    logic       rx_valid;
`endif

    spi_master_tx #(.CLK_DIV(CLK_DIV), .CS_IDLE(CS_IDLE)) dut (
        .clk_in         (clk),
        .rst_n_in       (rst_n),
        .byte_valid_in  (byte_valid),
        .byte_ready_out (byte_ready),
        .byte_data_in   (byte_data),
        .byte_last_in   (byte_last),
        .byte_done_out  (byte_done),
        .busy_out       (busy),
        .spi_sclk_out   (sclk),
        .spi_mosi_out   (mosi),
        .spi_cs_n_out   (cs_n)
`ifdef SPI_MISO_EN
        ,
        .spi_miso_in    (mosi),
        .rx_data_out    (rx_data),
        .rx_valid_out   (rx_valid)
`endif
    );

    // 10 time-unit clock
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] exp_q[$];

    // monitor state
    logic       p_cs = 1'b1, p_sclk = 1'b0, p_mosi = 1'b0;
    logic [7:0] rx_byte = 8'h00;
    int nbits = 0, hi_run = 0, low_len = 0, high_len = 0;
    int f_len = 0, f_rises = 0, f_maxlow = 0, f_minhigh = 1000, f_first = -1;
    int frames = 0, total_done = 0, mosi_glitch = 0;
    int last_len = 0, last_rises = 0, last_maxlow = 0, last_minhigh = 0, last_first = 0, last_gap = 0;
    bit in_frame = 1'b0, had_frame = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one byte (call just after a falling edge); queue it at handshake.
    task automatic send(input logic [7:0] d, input logic l);
        int t = 0;
        byte_valid = 1'b1;
        byte_data  = d;
        byte_last  = l;
        while (!byte_ready && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 1000) check("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        exp_q.push_back(d);
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        @(negedge clk);
        while (!(busy == 1'b0 && byte_ready == 1'b1) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) check("idle_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        fork
            // ---------------- monitor / scoreboard ----------------
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    exp_q.delete();
                    nbits = 0; rx_byte = 8'h00; in_frame = 1'b0; had_frame = 1'b0;
                    p_cs = 1'b1; p_sclk = 1'b0; p_mosi = 1'b0; hi_run = 0;
                end else begin
                    if (p_cs && !cs_n) begin
                        if (had_frame) last_gap = hi_run;
                        f_len = 0; f_rises = 0; f_maxlow = 0; f_minhigh = 1000;
                        low_len = 0; high_len = 0; f_first = -1; in_frame = 1'b1;
                    end
                    if (!cs_n) f_len++;
                    else hi_run = p_cs ? hi_run + 1 : 1;
                    if (!p_cs && cs_n && in_frame) begin
                        frames++;
                        last_len = f_len; last_rises = f_rises; last_maxlow = f_maxlow;
                        last_minhigh = f_minhigh; last_first = f_first;
                        had_frame = 1'b1; in_frame = 1'b0;
                    end
                    if (sclk) begin
                        if (!p_sclk) begin
                            high_len = 1;
                            f_rises++;
                            if (f_first < 0) f_first = f_len - 1;
                            if (low_len > f_maxlow) f_maxlow = low_len;
                            rx_byte = {rx_byte[6:0], mosi};
                            nbits++;
                        end else begin
                            high_len++;
                            if (mosi !== p_mosi) mosi_glitch++;
                        end
                    end else begin
                        if (p_sclk) begin
                            if (high_len < f_minhigh) f_minhigh = high_len;
                            low_len = 1;
                        end else begin
                            low_len++;
                        end
                    end
                    if (byte_done) begin
                        total_done++;
                        check("done_cs_low", {31'd0, cs_n}, 32'd0);
                        if (exp_q.size() == 0) begin
                            check("sb_unexpected_byte", {24'd0, rx_byte}, 32'hFFFF_FFFF);
                        end else begin
                            logic [7:0] e;
                            e = exp_q.pop_front();
                            check("sb_byte", {24'd0, rx_byte}, {24'd0, e});
                            check("sb_bits", nbits, 32'd8);
`ifdef SPI_MISO_EN
                            check("rx_valid", {31'd0, rx_valid}, 32'd1);
                            check("rx_data", {24'd0, rx_data}, {24'd0, e});
`endif
                        end
                        nbits = 0;
                    end
                    p_cs = cs_n; p_sclk = sclk; p_mosi = mosi;
                end
            end
            // ---------------- stimulus ----------------
            begin
                int fr0, d0, t;
                #12;
                check("rst_sclk",  {31'd0, sclk},       32'd0);
                check("rst_mosi",  {31'd0, mosi},       32'd0);
                check("rst_cs_n",  {31'd0, cs_n},       32'd1);
                check("rst_ready", {31'd0, byte_ready}, 32'd1);
                check("rst_done",  {31'd0, byte_done},  32'd0);
                check("rst_busy",  {31'd0, busy},       32'd0);
                @(negedge clk);
                rst_n = 1'b1;
                repeat (3) @(negedge clk);

                // single-byte frame
                fr0 = frames; d0 = total_done;
                send(8'hA5, 1'b1);
                wait_idle();
                check("t1_frames", frames - fr0, 32'd1);
                check("t1_cs_len", last_len, 17 * CLK_DIV);
                check("t1_rises", last_rises, 32'd8);
                check("t1_first_rise", last_first, CLK_DIV);
                check("t1_done_pulses", total_done - d0, 32'd1);

                // seamless three-byte stream
                fr0 = frames;
                send(8'h00, 1'b0);
                send(8'hFF, 1'b0);
                send(8'h3C, 1'b1);
                wait_idle();
                check("t2_frames", frames - fr0, 32'd1);
                check("t2_rises", last_rises, 32'd24);
                check("t2_cs_len", last_len, 49 * CLK_DIV);
                check("t2_max_low", last_maxlow, CLK_DIV);
                check("t2_min_high", last_minhigh, CLK_DIV);

                // starved stream enters WAIT
                fr0 = frames; d0 = total_done;
                send(8'h81, 1'b0);
                t = 0;
                while (total_done == d0 && t < 500) begin
                    @(negedge clk);
                    t++;
                end
                if (t >= 500) check("t3_done_timeout", 32'd0, 32'd1);
                repeat (10) @(negedge clk);
                check("t3_wait_sclk", {31'd0, sclk}, 32'd0);
                check("t3_wait_cs_n", {31'd0, cs_n}, 32'd0);
                check("t3_wait_busy", {31'd0, busy}, 32'd1);
                repeat (10) @(negedge clk);
                send(8'h7E, 1'b1);
                wait_idle();
                check("t3_frames", frames - fr0, 32'd1);
                check("t3_rises", last_rises, 32'd16);
                check("t3_long_low", {31'd0, (last_maxlow >= 20)}, 32'd1);

                // back-to-back frames
                fr0 = frames;
                send(8'h11, 1'b1);
                send(8'h22, 1'b1);
                wait_idle();
                check("t4_frames", frames - fr0, 32'd2);
                check("t4_gap", last_gap, CS_IDLE);
                check("t4_rises", last_rises, 32'd8);

                // asynchronous reset mid-byte
                send(8'hC3, 1'b1);
                t = 0;
                while (!(in_frame && f_rises >= 4) && t < 500) begin
                    @(negedge clk);
                    t++;
                end
                if (t >= 500) check("t5_rise_timeout", 32'd0, 32'd1);
                @(posedge clk);
                #2 rst_n = 1'b0;
                #1;
                check("t5_cs_n", {31'd0, cs_n}, 32'd1);
                check("t5_sclk", {31'd0, sclk}, 32'd0);
                check("t5_mosi", {31'd0, mosi}, 32'd0);
                check("t5_ready", {31'd0, byte_ready}, 32'd1);
                check("t5_busy", {31'd0, busy}, 32'd0);
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                fr0 = frames;
                send(8'h5A, 1'b1);
                wait_idle();
                check("t5_frames", frames - fr0, 32'd1);
                check("t5_cs_len", last_len, 17 * CLK_DIV);

`ifdef SPI_MISO_EN
                // loop-back receive
                send(8'h96, 1'b1);
                wait_idle();
`endif

                check("mosi_stable_high", mosi_glitch, 32'd0);
                check("sb_drained", exp_q.size(), 32'd0);
            end
        join_any
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
